// File: rtl/pixel_reader_3d.sv
// -----------------------------------------------------------------------------
// pixel_reader_3d
//
// Reads one frame of three-channel pixels from an upstream FIFO that has one
// cycle of read latency (normal, non-show-ahead mode). It streams the pixels
// out through a 2-entry skid buffer with valid/ready handshaking, and tags each
// beat with its row/column position. After the WIDTH*HEIGHT frame words, the
// block reads and throws away PAD_WORDS trailing pad words, then pulses
// frame_done.
//
// Ports
//   clk                 rising-edge clock
//   resetn              asynchronous active-low reset
//   start               one-cycle frame start request (honoured only in IDLE)
//   fifo_empty          upstream FIFO empty flag
//   fifo_data_0/1/2     upstream FIFO read data, valid the cycle after a read
//   fifo_rdreq          upstream FIFO read request (combinational)
//   out_valid           output beat valid
//   out_ready           downstream accept
//   out_data_0/1/2      pixel channels of the current beat
//   out_row, out_col    position of the current beat within the frame
//   out_last            current beat is the final pixel of the frame
//   frame_done          one-cycle pulse while in DONE
//   busy                state is not IDLE
// -----------------------------------------------------------------------------
module pixel_reader_3d #(
    parameter int DWIDTH    = 8,
    parameter int WIDTH     = 56,
    parameter int HEIGHT    = 56,
    parameter int PAD_WORDS = WIDTH + 2,
    parameter int CNTW      = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data_0,
    input  logic [DWIDTH-1:0] fifo_data_1,
    input  logic [DWIDTH-1:0] fifo_data_2,
    output logic              fifo_rdreq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data_0,
    output logic [DWIDTH-1:0] out_data_1,
    output logic [DWIDTH-1:0] out_data_2,
    output logic [CNTW-1:0]   out_row,
    output logic [CNTW-1:0]   out_col,
    output logic              out_last,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [CNTW-1:0] FRAME_LIM = CNTW'(WIDTH * HEIGHT);
    localparam logic [CNTW-1:0] PAD_LIM   = CNTW'(PAD_WORDS);
    localparam logic [CNTW-1:0] COL_MAX   = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] ROW_MAX   = CNTW'(HEIGHT - 1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state;
    logic [CNTW-1:0]   frame_cnt;
    logic [CNTW-1:0]   pad_cnt;
    logic [CNTW-1:0]   row_cnt;
    logic [CNTW-1:0]   col_cnt;

    // Read in flight (registered fifo_rdreq) and its discard tag.
    logic              vld_p1;
    logic              tag_p1;

    // 2-entry output buffer, each entry {ch0, ch1, ch2}.
    logic [3*DWIDTH-1:0] buf_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        occ;

    logic              below_lim;
    logic              room;
    logic              pop;
    logic              push;
    logic [2:0]        pending;

    assign pop  = out_valid & out_ready;
    assign push = vld_p1 & ~tag_p1;

    // A new read is allowed only if it will still fit when it lands a cycle
    // later: buffered words plus the read already in flight, less this
    // cycle's pop, must leave a free slot. pop implies occ >= 1, so the
    // subtraction cannot underflow.
    assign pending = {1'b0, occ} + {2'b00, vld_p1};
    assign room    = (pending - {2'b00, pop}) < 3'd2;

    always_comb begin
        below_lim = 1'b0;
        case (state)
            RUN:     below_lim = frame_cnt < FRAME_LIM;
            FLUSH:   below_lim = pad_cnt < PAD_LIM;
            default: below_lim = 1'b0;
        endcase
    end

    assign fifo_rdreq = ((state == RUN) || (state == FLUSH)) && !fifo_empty
                        && below_lim && room;

    assign out_valid  = (occ != 2'd0);
    assign {out_data_0, out_data_1, out_data_2} = buf_mem[rd_ptr];
    assign out_row    = row_cnt;
    assign out_col    = col_cnt;
    assign out_last   = out_valid && (row_cnt == ROW_MAX) && (col_cnt == COL_MAX);
    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

    // ---- control: state, issue counters, position counters, read tag ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            frame_cnt <= '0;
            pad_cnt   <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            vld_p1    <= 1'b0;
            tag_p1    <= 1'b0;
        end else begin
            vld_p1 <= fifo_rdreq;
            tag_p1 <= (state == FLUSH);

            // Counters only advance on an issued read, and fifo_rdreq is
            // gated by below_lim, so they stop at their limits.
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        frame_cnt <= '0;
                        pad_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (fifo_rdreq) begin
                        frame_cnt <= frame_cnt + CNT_ONE;
                        // Leave on the cycle the last frame read issues so
                        // the pad reads follow without a bubble.
                        if (frame_cnt == FRAME_LIM - CNT_ONE) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_rdreq) begin
                        pad_cnt <= pad_cnt + CNT_ONE;
                    end
                    if ((pad_cnt == PAD_LIM) && !vld_p1 && (occ == 2'd0)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if ((state == IDLE) && start) begin
                row_cnt <= '0;
                col_cnt <= '0;
            end else if (pop) begin
                if (col_cnt == COL_MAX) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + CNT_ONE;
                end else begin
                    col_cnt <= col_cnt + CNT_ONE;
                end
            end
        end
    end

    // ---- output buffer: written the cycle after a frame read, pad words dropped ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            occ        <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= {fifo_data_0, fifo_data_1, fifo_data_2};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: doc/pixel_reader_3d.md
PIXEL_READER_3D -- requirements
Module: pixel_reader_3d

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, giving the bits per channel word.
REQ-002 The block SHALL have parameter WIDTH, default 56, giving pixels per row.
REQ-003 The block SHALL have parameter HEIGHT, default 56, giving rows per frame.
REQ-004 The block SHALL have parameter PAD_WORDS, default WIDTH+2, giving the trailing pad words per frame.
REQ-005 The block SHALL have parameter CNTW, default 12, giving the counter width; it SHALL be at least clog2(WIDTH*HEIGHT+PAD_WORDS+1).
REQ-006 The block SHALL have these ports:
- clk, input, 1 bit: the single clock; all logic is rising-edge.
- resetn, input, 1 bit: asynchronous, active-low reset.
- start, input, 1 bit: one-cycle frame start request.
- fifo_empty, input, 1 bit: upstream FIFO empty flag.
- fifo_data_0/1/2, input, DWIDTH bits each: FIFO read data, normal (non-show-ahead) mode.
- fifo_rdreq, output, 1 bit: FIFO read request.
- out_valid, output, 1 bit: output beat valid.
- out_ready, input, 1 bit: downstream accept.
- out_data_0/1/2, output, DWIDTH bits each: pixel channels.
- out_row, output, CNTW bits: row index of the current beat.
- out_col, output, CNTW bits: column index of the current beat.
- out_last, output, 1 bit: final pixel of the frame.
- frame_done, output, 1 bit: one-cycle completion pulse.
- busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-007 The state machine SHALL have exactly four states: IDLE, RUN, FLUSH, DONE.
REQ-008 Transitions:
- IDLE to RUN on start=1.
- RUN to FLUSH when WIDTH*HEIGHT frame reads have been issued.
- FLUSH to DONE when PAD_WORDS pad reads have been issued, no read is in flight and the buffer is empty.
- DONE to IDLE unconditionally after one cycle.
REQ-009 start SHALL be ignored in every state except IDLE.
REQ-010 FIFO data SHALL be sampled on the cycle after a cycle with fifo_rdreq=1 (one-cycle read latency).
REQ-011 fifo_rdreq SHALL be combinational and equal to: state is RUN or FLUSH, AND fifo_empty=0, AND the issue count is below its limit, AND (occupancy + inflight - pop) < 2.
- occupancy is the 2-entry output buffer count.
- inflight is the registered fifo_rdreq.
- pop = out_valid AND out_ready.
REQ-012 Each in-flight read SHALL carry a registered discard tag: 0 for frame reads, 1 for pad reads.
REQ-013 Returned words with tag 0 SHALL be written into the buffer; words with tag 1 SHALL be dropped.
REQ-014 The output buffer SHALL be a 2-entry FIFO of {ch0,ch1,ch2}, and out_data SHALL present its head entry.
REQ-015 out_valid SHALL equal (occupancy != 0).
REQ-016 Output data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-017 A simultaneous push and pop SHALL be legal at occupancy 1 or 2, and occupancy SHALL be unchanged.
REQ-018 Sustained throughput SHALL be 1 pixel/clk when fifo_empty=0 and out_ready=1.
REQ-019 Latency from the first fifo_rdreq to the first out_valid SHALL be 2 clk.
REQ-020 out_col SHALL increment on each pop and wrap from WIDTH-1 to 0.
REQ-021 out_row SHALL increment on each out_col wrap.
REQ-022 out_row and out_col SHALL both be 0 for the first beat of each frame.
REQ-023 out_last SHALL be 1 only when out_valid=1, out_row=HEIGHT-1 and out_col=WIDTH-1.
REQ-024 The frame and pad issue counters SHALL saturate at their limits and never wrap.
REQ-025 The frame and pad issue counters and the row/column counters SHALL be cleared on entry to RUN.
REQ-026 frame_done SHALL be 1 exactly during the DONE cycle.
REQ-027 busy SHALL be the inverse of (state == IDLE).
REQ-028 While fifo_empty=1, no read SHALL be issued, and already-buffered data SHALL still drain.

Reset
REQ-029 resetn=0 SHALL immediately force the following, regardless of clock:
- state to IDLE;
- all counters, occupancy, inflight and discard tag to 0;
- fifo_rdreq, out_valid, out_last, frame_done and busy to 0;
- out_data, out_row and out_col to 0.
REQ-030 A reset asserted mid-frame SHALL discard all buffered and in-flight data.
REQ-031 After reset deassertion, the block SHALL wait in IDLE for a new start.

Verification
All scenarios use WIDTH=4, HEIGHT=2, PAD_WORDS=6.
REQ-032 Streaming scenario:
- Stimulus: start pulse, FIFO preloaded with 8 frame words 0x01..0x08 and 6 pad words, out_ready=1.
- Response: fifo_rdreq high for 14 consecutive cycles; out beats 0x01..0x08 with (row,col) running (0,0)..(1,3); out_last on 0x08; pad words never output; frame_done one pulse; busy then 0.
REQ-033 Backpressure scenario:
- Stimulus: out_ready=0 from the 3rd beat for 5 cycles.
- Response: fifo_rdreq stops once occupancy+inflight=2; beat 0x03 held stable; no beat lost or duplicated; order preserved after release.
REQ-034 Empty-FIFO scenario:
- Stimulus: fifo_empty=1 for 3 cycles mid-frame.
- Response: no fifo_rdreq during those cycles; the buffer drains to out_valid=0; streaming resumes with the next value in sequence.
REQ-035 Ignored-start scenario:
- Stimulus: start asserted during RUN and during FLUSH.
- Response: no effect; the frame completes normally with exactly one frame_done.
REQ-036 Reset scenario:
- Stimulus: resetn=0 after the 5th beat, then a new start with fresh data 0x11..0x18.
- Response: all outputs 0 immediately at reset; the new frame starts at (0,0) with 0x11.
REQ-037 Back-to-back scenario:
- Stimulus: start asserted on the cycle after frame_done.
- Response: a second complete frame with correct indices and pad discard.
